// File: rtl/spi_maestro_registros.sv
// Register-mapped SPI mode-0 master: 256x8 data buffer plus control register,
// full-duplex burst over buffer bytes with in-place write-back of received data.
module spi_maestro_registros #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned PROF = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic        reg_sel_i,
    input  logic [31:0] entrada_i,
    input  logic [31:0] addr_i,
    output logic [31:0] salida_o,
    output logic        sclk_o,
    output logic        mosi_o,
    input  logic        miso_i,
    output logic        cs_o
);
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 8;
    localparam int unsigned NRXW = 10;
    localparam int unsigned BW   = 3;
    localparam int unsigned CW   = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARGA,
        S_ALTO,
        S_BAJO,
        S_GUARDA,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_buf [PROF];

    logic            r_send,     w_send_nxt;
    logic            r_cs_ctrl,  w_cs_ctrl_nxt;
    logic            r_all1,     w_all1_nxt;
    logic            r_all0,     w_all0_nxt;
    logic [AW-1:0]   r_n_tx_end, w_n_tx_end_nxt;
    logic [NRXW-1:0] r_n_rx,     w_n_rx_nxt;
    logic [AW-1:0]   r_idx,      w_idx_nxt;
    logic [DW-1:0]   r_shreg,    w_shreg_nxt;
    logic [DW-1:0]   r_rxreg,    w_rxreg_nxt;
    logic [BW-1:0]   r_bit,      w_bit_nxt;
    logic [CW-1:0]   r_div,      w_div_nxt;
    logic            r_sclk,     w_sclk_nxt;
    logic            r_mosi,     w_mosi_nxt;
    logic            r_cs,       w_cs_nxt;
    logic [31:0]     r_salida;

    logic            w_wr_ok;
    logic            w_wb;
    logic            w_div_end;
    logic [AW-1:0]   w_load_idx;
    logic [DW-1:0]   w_tx;
    logic [31:0]     w_ctrl;
    logic [31:0]     w_rd;
    logic            w_unused_bits;

    assign w_wr_ok    = wr_i && (r_state == S_IDLE) && !r_send;
    assign w_div_end  = (r_div == CW'(DIV - 1));
    // Byte index about to be loaded: restart at 0 from IDLE, else advance.
    assign w_load_idx = (r_state == S_IDLE) ? '0 : r_idx + AW'(1);
    assign w_tx       = r_all1 ? 8'hFF : (r_all0 ? 8'h00 : r_buf[w_load_idx]);
    assign w_ctrl     = {6'b0, r_n_rx, 4'b0, r_n_tx_end, r_all0, r_all1, r_cs_ctrl, r_send};
    assign w_rd       = reg_sel_i ? {24'b0, r_buf[addr_i[AW-1:0]]} : w_ctrl;
    assign w_unused_bits = ^{entrada_i[31:12], addr_i[31:AW]};

    assign salida_o = r_salida;
    assign sclk_o   = r_sclk;
    assign mosi_o   = r_mosi;
    assign cs_o     = r_cs;

    always_comb begin
        w_state_nxt    = r_state;
        w_send_nxt     = r_send;
        w_cs_ctrl_nxt  = r_cs_ctrl;
        w_all1_nxt     = r_all1;
        w_all0_nxt     = r_all0;
        w_n_tx_end_nxt = r_n_tx_end;
        w_n_rx_nxt     = r_n_rx;
        w_idx_nxt      = r_idx;
        w_shreg_nxt    = r_shreg;
        w_rxreg_nxt    = r_rxreg;
        w_bit_nxt      = r_bit;
        w_div_nxt      = r_div;
        w_sclk_nxt     = 1'b0;
        w_mosi_nxt     = r_mosi;
        w_cs_nxt       = r_cs;
        w_wb           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cs_nxt   = ~r_cs_ctrl;
                w_mosi_nxt = 1'b0;
                if (w_wr_ok && !reg_sel_i) begin
                    w_send_nxt     = entrada_i[0];
                    w_cs_ctrl_nxt  = entrada_i[1];
                    w_all1_nxt     = entrada_i[2];
                    w_all0_nxt     = entrada_i[3];
                    w_n_tx_end_nxt = entrada_i[11:4];
                    w_n_rx_nxt     = '0;
                end
                if (r_send) begin
                    w_state_nxt = S_CARGA;
                    w_idx_nxt   = w_load_idx;
                    w_shreg_nxt = w_tx;
                    w_mosi_nxt  = w_tx[DW-1];
                    w_cs_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                    w_div_nxt   = '0;
                end
            end
            S_CARGA: begin
                w_cs_nxt = 1'b0;
                if (w_div_end) begin
                    w_state_nxt = S_ALTO;
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_rxreg_nxt = {r_rxreg[DW-2:0], miso_i};
                end else begin
                    w_div_nxt = r_div + CW'(1);
                end
            end
            S_ALTO: begin
                w_cs_nxt = 1'b0;
                if (w_div_end) begin
                    w_state_nxt = S_BAJO;
                    w_div_nxt   = '0;
                    w_shreg_nxt = {r_shreg[DW-2:0], 1'b0};
                    w_mosi_nxt  = r_shreg[DW-2];
                end else begin
                    w_div_nxt  = r_div + CW'(1);
                    w_sclk_nxt = 1'b1;
                end
            end
            S_BAJO: begin
                w_cs_nxt = 1'b0;
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (r_bit == BW'(DW - 1)) begin
                        w_state_nxt = S_GUARDA;
                    end else begin
                        w_state_nxt = S_ALTO;
                        w_bit_nxt   = r_bit + BW'(1);
                        w_sclk_nxt  = 1'b1;
                        w_rxreg_nxt = {r_rxreg[DW-2:0], miso_i};
                    end
                end else begin
                    w_div_nxt = r_div + CW'(1);
                end
            end
            S_GUARDA: begin
                w_wb       = 1'b1;
                w_n_rx_nxt = r_n_rx + NRXW'(1);
                if (r_idx == r_n_tx_end) begin
                    w_state_nxt = S_FIN;
                    w_cs_nxt    = ~r_cs_ctrl;
                    w_mosi_nxt  = 1'b0;
                end else begin
                    // CS stays asserted across byte boundaries.
                    w_state_nxt = S_CARGA;
                    w_idx_nxt   = w_load_idx;
                    w_shreg_nxt = w_tx;
                    w_mosi_nxt  = w_tx[DW-1];
                    w_cs_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                    w_div_nxt   = '0;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_send_nxt  = 1'b0;
                w_cs_nxt    = ~r_cs_ctrl;
                w_mosi_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state    <= S_IDLE;
            r_send     <= 1'b0;
            r_cs_ctrl  <= 1'b0;
            r_all1     <= 1'b0;
            r_all0     <= 1'b0;
            r_n_tx_end <= '0;
            r_n_rx     <= '0;
            r_idx      <= '0;
            r_shreg    <= '0;
            r_rxreg    <= '0;
            r_bit      <= '0;
            r_div      <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_salida   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_send     <= w_send_nxt;
            r_cs_ctrl  <= w_cs_ctrl_nxt;
            r_all1     <= w_all1_nxt;
            r_all0     <= w_all0_nxt;
            r_n_tx_end <= w_n_tx_end_nxt;
            r_n_rx     <= w_n_rx_nxt;
            r_idx      <= w_idx_nxt;
            r_shreg    <= w_shreg_nxt;
            r_rxreg    <= w_rxreg_nxt;
            r_bit      <= w_bit_nxt;
            r_div      <= w_div_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs       <= w_cs_nxt;
            r_salida   <= w_rd;
        end
    end

    // Buffer is never cleared; a reset cycle suppresses any pending write-back.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (w_wb) begin
                r_buf[r_idx] <= r_rxreg;
            end else if (w_wr_ok && reg_sel_i) begin
                r_buf[addr_i[AW-1:0]] <= entrada_i[DW-1:0];
            end
        end
    end

endmodule

// File: doc/spi_maestro_registros.md
Name: spi_maestro_registros

Overview:
- Register-mapped SPI master: the peripheral side of the bus driven by the test data/control generator.
- Accepts wr/reg_sel/entrada/addr writes into a 256x8 data buffer and a 32-bit control register.
- Runs a full-duplex SPI mode-0 burst over buffer bytes and overwrites each byte with the received byte.
- Exposes status and buffer contents on salida_o for polling.

Parameters:
- DIV, 4, SCLK half-period in clk_i cycles (SCLK period = 2*DIV); legal range >= 2.
- PROF, 256, buffer depth in bytes; address uses addr_i[7:0].

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous reset, active-low
- wr_i  in  1  write strobe, sampled every clk_i rising edge
- reg_sel_i  in  1  0 = control register, 1 = data buffer
- entrada_i  in  32  write data; buffer uses [7:0]
- addr_i  in  32  buffer address; only [7:0] used, [31:8] ignored
- salida_o  out  32  read data, registered
- sclk_o  out  1  SPI clock, idle low
- mosi_o  out  1  SPI data out, MSB first
- miso_i  in  1  SPI data in
- cs_o  out  1  chip select, active-low

Behaviour:
- Reset (reset_i=0 at a clk edge):
  - Control register = 0; FSM = IDLE.
  - Outputs: salida_o=0, sclk_o=0, mosi_o=0, cs_o=1.
  - Buffer contents are not cleared.
  - Reset during a burst aborts it immediately; no partial byte is written back.
- Control register fields:
  - [0] send: set by SW, cleared by HW at burst end.
  - [1] cs_ctrl: 1 forces cs_o=0 while IDLE.
  - [2] all_1s: transmit 0xFF instead of buffer data.
  - [3] all_0s: transmit 0x00 instead of buffer data; all_1s has priority.
  - [11:4] n_tx_end: last buffer index of the burst (burst length = n_tx_end+1).
  - [25:16] n_rx: bytes completed, read-only, HW-written.
  - All other bits read 0.
- Writes, IDLE only:
  - wr_i=1, reg_sel_i=1: buf[addr_i[7:0]] <= entrada_i[7:0].
  - wr_i=1, reg_sel_i=0: control[11:0] <= entrada_i[11:0]; n_rx cleared to 0.
  - If entrada_i[0]=1, leave IDLE next cycle.
- Writes while busy (send=1) are ignored, for both buffer and control.
- Reads:
  - Every cycle, salida_o <= reg_sel_i ? {24'b0, buf[addr_i[7:0]]} : control. Latency 1 clk.
  - Reads are allowed while busy; the byte currently in flight shows its old value until its write-back.
- FSM states:
  - IDLE: cs_o = ~cs_ctrl, sclk_o=0. Go to CARGA when send=1.
  - CARGA: idx <= 0 on first entry; shreg <= tx byte (buf[idx] or 0xFF/0x00 override); cs_o=0; mosi_o=shreg[7]; bit counter=0. Hold one DIV period (CS setup). Go to ALTO.
  - ALTO: sclk_o=1; sample miso_i into rxreg LSB-shift on entry cycle; hold DIV cycles. Go to BAJO.
  - BAJO: sclk_o=0; shift shreg left; mosi_o = next bit; hold DIV cycles. After bit 7 go to GUARDA, else go to ALTO.
  - GUARDA (1 clk): buf[idx] <= rxreg; n_rx <= n_rx+1. If idx==n_tx_end go to FIN, else idx <= idx+1 and go to CARGA with no CS release between bytes.
  - FIN (1 clk): send <= 0, cs_o=1 (or 0 if cs_ctrl), sclk_o=0. Go to IDLE.
- SPI timing:
  - Mode 0: MOSI is stable one DIV before each rising edge; MISO is sampled at the rising edge.
  - Exactly 8 SCLK pulses per byte; SCLK stays low between bytes (CARGA period).
- Boundaries:
  - n_tx_end=0 transfers 1 byte; n_tx_end=255 transfers all 256 bytes with n_rx=256; idx never wraps.
  - Control write with send=0 only updates fields.
  - send=1 from IDLE with a same-cycle read of control returns the pre-write value.

Test Plan:
- Reset values: reset_i=0 for 2 clk -> salida_o=0, cs_o=1, sclk_o=0, mosi_o=0; control read after release = 0.
- Buffer write/read: write 0xA5 to addr 0x12 (reg_sel=1), then read addr 0x12 -> salida_o=0x000000A5 one clk later; addr_i=0x112 aliases to 0x12.
- Single-byte burst, miso looped to mosi:
  - Stimulus: buf[0]=0x3C, write control 0x001.
  - Exactly 8 SCLK pulses of period 2*DIV, MOSI bits 0,0,1,1,1,1,0,0.
  - Control bit0 reads 0 afterwards; n_rx=1; buf[0]=0x3C.
- Full burst with miso tied 1 and all_0s: write control 0xFD5 (n_tx_end=0xFD, all_1s=1... use 0xFD9 for all_0s) -> mosi_o stays 0; 254 bytes; buf[0..0xFD]=0xFF; buf[0xFE]=old value; n_rx=254; send cleared.
- Busy protection: during a burst, write buf[5]=0x77 and control=0 -> both ignored; burst completes normally; polling salida_o[0] returns 1 until FIN, then 0.
- Reset mid-burst: assert reset_i=0 during bit 3 of byte 2 -> next clk cs_o=1, sclk_o=0, control=0; buf[2] keeps its pre-burst value.
